// File: rtl/pipe_div_unit.sv
// Iterative restoring signed/unsigned divider for the EX stage, with annul and defined divide-by-zero.
// Define DIV_ZERO_FAST_EN to finish a divide by zero one cycle after start.
module pipe_div_unit #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             annul,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    logic [WIDTH-1:0] abs_dividend, abs_divisor;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    always_comb begin
        abs_dividend = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
        abs_divisor  = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;

        // A set top bit means the shifted remainder already exceeds any WIDTH-bit divisor.
        shifted = {rem_q, dvd_q[WIDTH-1]};
        borrow  = ~shifted[WIDTH] & (shifted[WIDTH-1:0] < dvs_q);
        diff    = shifted[WIDTH-1:0] - dvs_q;

        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = abs_dividend;
                    dvs_d   = abs_divisor;
                    rem_d   = '0;
                    cnt_d   = '0;
                    qneg_d  = signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    rneg_d  = signed_div & dividend[WIDTH-1];
                    state_d = CALC;
`ifdef DIV_ZERO_FAST_EN
                    if (divisor == '0) begin
                        quotient_d  = (signed_div && dividend[WIDTH-1]) ? WIDTH'(1) : '1;
                        remainder_d = dividend;
                        done_d      = 1'b1;
                        state_d     = DONE;
                    end
`endif
                end
            end
            CALC: begin
                rem_d = borrow ? shifted[WIDTH-1:0] : diff;
                dvd_d = {dvd_q[WIDTH-2:0], ~borrow};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                quotient_d  = qneg_q ? -dvd_q : dvd_q;
                remainder_d = rneg_q ? -rem_q : rem_q;
                done_d      = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush wins over everything; the visible results must never move on an annul.
        if (annul) begin
            state_d     = IDLE;
            done_d      = 1'b0;
            quotient_d  = quotient_q;
            remainder_d = remainder_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign busy      = ((state_q == IDLE) & start & ~annul) | (state_q == CALC) | (state_q == SIGN);
    assign done      = done_q & ~annul;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_pipe_div_unit.sv
// Directed scoreboard bench for pipe_div_unit at WIDTH=32: results, latency, busy, annul and reset.
// Expected values come from a behavioural model of the divide semantics, queued at each start.
module tb_pipe_div_unit;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] lat;
    } result_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic        annul;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int      checks = 0;
    int      errors = 0;
    result_t sb[$];

    pipe_div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_div(signed_div),
        .annul     (annul),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference semantics: truncating division, overflow wraps, divide by zero is defined.
    function automatic result_t model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        result_t res;
        res.lat = 32'd34;
        if (b == 32'd0) begin
            res.r = a;
            res.q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
`ifdef DIV_ZERO_FAST_EN
            res.lat = 32'd1;
`endif
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res.q = 32'h8000_0000;
            res.r = 32'd0;
        end else if (sgn) begin
            res.q = $signed(a) / $signed(b);
            res.r = $signed(a) % $signed(b);
        end else begin
            res.q = a / b;
            res.r = a % b;
        end
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called in the low clock phase; returns just after the sampling edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        sb.push_back(model(a, b, sgn));
        dividend   = a;
        divisor    = b;
        signed_div = sgn;
        start      = 1'b1;
        #1;
        checkOutput("busy_at_start", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        result_t e;
        int      k;
        bit      seen;
        bit      busy_ok;
        if (sb.size() == 0) begin
            checkOutput({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
            return;
        end
        e       = sb.pop_front();
        seen    = 1'b0;
        busy_ok = 1'b1;
        k       = 0;
        while (!seen && k < 60) begin
            k++;
            @(negedge clk);
            #1;
            if (done === 1'b1) seen = 1'b1;
            else if (busy !== 1'b1) busy_ok = 1'b0;
        end
        checkOutput({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            checkOutput({tag, "_busy_while_running"}, {31'd0, busy_ok}, 32'd1);
            checkOutput({tag, "_latency"}, 32'(k), e.lat);
            checkOutput({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
            checkOutput({tag, "_quotient"}, quotient, e.q);
            checkOutput({tag, "_remainder"}, remainder, e.r);
            // A start presented during the done cycle must be ignored.
            dividend   = 32'd77;
            divisor    = 32'd5;
            signed_div = 1'b0;
            start      = 1'b1;
            #1;
            checkOutput({tag, "_start_in_done_busy"}, {31'd0, busy}, 32'd0);
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            #1;
            checkOutput({tag, "_idle_after_done"}, {30'd0, busy, done}, 32'd0);
        end
    endtask

    task automatic expectNoDone(input string tag, input int cycles);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) hit = 1'b1;
        end
        checkOutput({tag, "_quiet"}, {31'd0, hit}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        dividend   = 32'd0;
        divisor    = 32'd0;
        #1;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_quotient", quotient, 32'd0);
        checkOutput("reset_remainder", remainder, 32'd0);
        #12;
        @(negedge clk);
        rst = 1'b0;
        #1;

        $display("[TB] basic signed and unsigned divides");
        applyStimulus(32'd7, 32'd2, 1'b0);
        waitDone("u7_2");
        applyStimulus(-32'sd7, 32'd2, 1'b1);
        waitDone("s-7_2");
        applyStimulus(32'd7, -32'sd2, 1'b1);
        waitDone("s7_-2");
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        waitDone("s_overflow");
        applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0);
        waitDone("u_max_1");
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        waitDone("u_big");

        $display("[TB] divide by zero");
        applyStimulus(32'd5, 32'd0, 1'b0);
        waitDone("u5_0");
        applyStimulus(-32'sd5, 32'd0, 1'b1);
        waitDone("s-5_0");
        applyStimulus(32'd5, 32'd0, 1'b1);
        waitDone("s5_0");

        $display("[TB] annul mid-operation");
        applyStimulus(32'd100, 32'd7, 1'b0);
        waitDone("u100_7");
        applyStimulus(32'd50, 32'd3, 1'b0);
        void'(sb.pop_back());
        for (int i = 0; i < 10; i++) @(negedge clk);
        annul = 1'b1;
        #1;
        checkOutput("annul_busy_calc", {31'd0, busy}, 32'd1);
        checkOutput("annul_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        annul = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("after_annul_busy", {31'd0, busy}, 32'd0);
        checkOutput("after_annul_done", {31'd0, done}, 32'd0);
        checkOutput("after_annul_quotient", quotient, 32'd14);
        checkOutput("after_annul_remainder", remainder, 32'd2);
        @(negedge clk);
        #1;
        applyStimulus(32'd1000, 32'd10, 1'b0);
        waitDone("u1000_10");

        $display("[TB] annul together with start");
        start      = 1'b1;
        annul      = 1'b1;
        dividend   = 32'd9;
        divisor    = 32'd3;
        signed_div = 1'b0;
        #1;
        checkOutput("annul_start_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        annul = 1'b0;
        expectNoDone("annul_start", 40);
        checkOutput("annul_start_quotient", quotient, 32'd100);

        $display("[TB] reset during an operation");
        @(negedge clk);
        #1;
        applyStimulus(32'd123456, 32'd7, 1'b1);
        void'(sb.pop_back());
        for (int i = 0; i < 5; i++) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("mid_reset_done", {31'd0, done}, 32'd0);
        checkOutput("mid_reset_quotient", quotient, 32'd0);
        checkOutput("mid_reset_remainder", remainder, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expectNoDone("post_reset", 40);

        $display("[TB] random operands");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            applyStimulus($urandom, $urandom >> (i * 4), i[0]);
            waitDone("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_div_unit.md
Name: pipe_div_unit

Overview:
- Parametrised iterative signed/unsigned integer divider for the EX stage of the pipelined MIPS core.
- Produces the EX-stage divide stall, is cancelled by the exception flush, and delivers quotient and remainder for HI/LO writeback.
- Generalises the fixed 32-bit divide path to any WIDTH.
- Adds mid-operation annul and a defined divide-by-zero result.

Parameters:
- WIDTH, 32, operand/result width in bits (must be ≥ 4)
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a divide; sampled only in IDLE
- signed_div  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- annul  in  1  exception flush; cancels any operation in progress
- dividend  in  WIDTH  numerator; sampled with start
- divisor  in  WIDTH  denominator; sampled with start
- busy  out  1  stall request to the pipeline (combinational)
- done  out  1  one-cycle pulse; results valid
- quotient  out  WIDTH  registered quotient (to LO)
- remainder  out  WIDTH  registered remainder (to HI)

Behaviour:
- Reset (async, active-high):
  - state = IDLE, counter = 0, done = 0, quotient = 0, remainder = 0.
  - Any operation in progress is abandoned.
- States: IDLE, CALC, SIGN, DONE.
- IDLE:
  - start=1 and annul=0 at cycle T: latch |dividend| and |divisor| (absolute values only when signed_div=1, else raw).
  - Also latch the result signs: qneg = signs differ; rneg = dividend sign.
  - Go to CALC with counter = 0.
- CALC:
  - One restoring step per cycle: shift the partial remainder left with the next dividend bit, trial-subtract the divisor, and keep the difference when it is non-negative.
  - Quotient bit = NOT borrow.
  - Runs WIDTH cycles (T+1 .. T+WIDTH), then goes to SIGN.
- SIGN (T+WIDTH+1):
  - quotient = qneg ? −q : q; remainder = rneg ? −r : r (two's complement, WIDTH bits, wrap).
  - Go to DONE.
- DONE (T+WIDTH+2):
  - done = 1 for exactly this cycle; go to IDLE.
  - start is ignored in DONE.
- Latency: start at T → done at T+WIDTH+2 (T+34 for WIDTH=32). Throughput: one divide per WIDTH+3 cycles.
- busy = (IDLE & start & ~annul) | CALC | SIGN.
  - busy is low in DONE so the stage advances while the results are valid.
- quotient/remainder hold their value until the next SIGN write. They are never changed by annul.
- Signed overflow: −2^(WIDTH−1) / −1 gives quotient = −2^(WIDTH−1) and remainder = 0. No trap.
- Divide by zero (baseline):
  - unsigned: quotient = all ones, remainder = dividend.
  - signed: remainder = dividend; quotient = all ones if dividend ≥ 0, else 1.
- annul:
  - annul=1 in any state forces IDLE on the next edge; done stays 0.
  - annul with start in the same IDLE cycle: no operation begins and busy = 0.
  - annul has priority over start and over the DONE pulse. done is 0 in a cycle where annul=1.

Optional Feature:
- DIV_ZERO_FAST_EN defined:
  - A start with divisor = 0 skips CALC and SIGN.
  - The divide-by-zero result values above are written directly, and the block enters DONE at T+1.
  - busy is high only in cycle T.
- Not defined: divide by zero takes the full WIDTH+2 latency with the same result values.

Test Plan:
- Unsigned 7 / 2, WIDTH=32, start at T → busy high T..T+33, done at T+34, quotient=0x00000003, remainder=0x00000001.
- Signed −7 / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; signed 7 / −2 → quotient=0xFFFFFFFD, remainder=0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0x00000000, done at T+34, no other flag.
- After a completed 100/7 (q=14, r=2), start 50/3 then annul at T+10 → busy low from T+11, no done pulse, outputs remain q=14, r=2; a new start at T+12 completes normally at T+46.
- Unsigned 5 / 0 → quotient=0xFFFFFFFF, remainder=5. done at T+34, or at T+1 with DIV_ZERO_FAST_EN.
- Assert rst at T+5 of an operation → immediately state IDLE, busy=0, done=0, quotient=remainder=0; no done pulse after release.
